// File: rtl/matmul_sequencer.sv
// Walks every (row, column) pair of a matrix multiply, issuing A/B read addresses and
// writing each dot product to output memory LAT cycles later. MATMUL_SEQ_PERF_CNT_EN adds cycle_cnt.
module matmul_sequencer #(
    parameter int A_ROWS     = 64,
    parameter int B_COLS     = 64,
    parameter int ADDR_A_W   = 6,
    parameter int ADDR_B_W   = 6,
    parameter int ADDR_OUT_W = 12,
    parameter int MEM_LAT    = 1,
    parameter int TREE_LAT   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MATMUL_SEQ_PERF_CNT_EN
    output logic [31:0]           cycle_cnt,
`endif
    input  logic                  start,
    input  logic                  pause,
    output logic                  en_A,
    output logic                  we_A,
    output logic [ADDR_A_W-1:0]   addr_a,
    output logic                  en_B,
    output logic                  we_B,
    output logic [ADDR_B_W-1:0]   addr_b,
    output logic                  en_out,
    output logic                  we_out,
    output logic [ADDR_OUT_W-1:0] addr_out,
    output logic                  busy,
    output logic                  done
);

    localparam int LAT = MEM_LAT + TREE_LAT;

    // state   | meaning
    // S_IDLE  | after reset, waiting for start
    // S_ISSUE | one pair issued per unpaused cycle
    // S_DRAIN | all pairs issued, waiting for in-flight results to be written
    // S_DONE  | run complete, done held until the next start
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_A_W-1:0]   i_q, i_d;
    logic [ADDR_B_W-1:0]   j_q, j_d;
    logic                  en_ab_q, en_ab_d;
    logic [ADDR_A_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_B_W-1:0]   addr_b_q, addr_b_d;
    logic                  we_out_q, we_out_d;
    logic [ADDR_OUT_W-1:0] addr_out_q, addr_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LAT-1:0]        dl_vld_q, dl_vld_d;
    logic [ADDR_OUT_W-1:0] dl_idx_q [LAT];
    logic [ADDR_OUT_W-1:0] dl_idx_d [LAT];

    logic                  accept_start;
    logic                  issue_now;
    logic                  cur_last;
    logic                  dl_empty;
    logic [ADDR_A_W-1:0]   cur_i;
    logic [ADDR_B_W-1:0]   cur_j;
    logic [ADDR_OUT_W-1:0] cur_idx;

    assign dl_empty = ~|dl_vld_q;

    // A start issues pair (0,0) on the same edge, so the counters are bypassed to zero.
    assign cur_i    = accept_start ? '0 : i_q;
    assign cur_j    = accept_start ? '0 : j_q;
    assign cur_last = (cur_i == ADDR_A_W'(A_ROWS - 1)) && (cur_j == ADDR_B_W'(B_COLS - 1));
    assign cur_idx  = ADDR_OUT_W'(cur_i) * ADDR_OUT_W'(B_COLS) + ADDR_OUT_W'(cur_j);

    always_comb begin
        accept_start = 1'b0;
        issue_now    = 1'b0;
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = S_ISSUE;
                    i_d          = '0;
                    j_d          = '0;
                    issue_now    = !pause;
                end
            end
            S_ISSUE: begin
                issue_now = !pause;
            end
            S_DRAIN: begin
                if (dl_empty) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_now) begin
            if (cur_j == ADDR_B_W'(B_COLS - 1)) begin
                j_d = '0;
                i_d = cur_i + ADDR_A_W'(1);
            end else begin
                j_d = cur_j + ADDR_B_W'(1);
                i_d = cur_i;
            end
            if (cur_last) begin
                state_d = S_DRAIN;
            end
        end
    end

    // The delay line mirrors memory + tree latency and shifts every cycle, paused or not.
    always_comb begin
        dl_vld_d    = '0;
        dl_idx_d    = dl_idx_q;
        dl_vld_d[0] = issue_now;
        dl_idx_d[0] = cur_idx;
        for (int k = 1; k < LAT; k++) begin
            dl_vld_d[k] = dl_vld_q[k-1];
            dl_idx_d[k] = dl_idx_q[k-1];
        end
    end

    always_comb begin
        en_ab_d    = issue_now;
        addr_a_d   = issue_now ? cur_i : addr_a_q;
        addr_b_d   = issue_now ? cur_j : addr_b_q;
        we_out_d   = dl_vld_q[LAT-1];
        addr_out_d = dl_vld_q[LAT-1] ? dl_idx_q[LAT-1] : addr_out_q;
        busy_d     = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            en_ab_q    <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            we_out_q   <= 1'b0;
            addr_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dl_vld_q   <= '0;
            for (int k = 0; k < LAT; k++) begin
                dl_idx_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            en_ab_q    <= en_ab_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            we_out_q   <= we_out_d;
            addr_out_q <= addr_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dl_vld_q   <= dl_vld_d;
            for (int k = 0; k < LAT; k++) begin
                dl_idx_q[k] <= dl_idx_d[k];
            end
        end
    end

`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (accept_start) begin
            cycle_cnt_d = '0;
        end else if (busy_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

    assign en_A     = en_ab_q;
    assign en_B     = en_ab_q;
    assign we_A     = 1'b0;
    assign we_B     = 1'b0;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign en_out   = we_out_q;
    assign we_out   = we_out_q;
    assign addr_out = addr_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: random A/B data through a memory+tree model, random and
// directed pause, reset mid-run, ignored starts, restart from done; cycle_cnt under MATMUL_SEQ_PERF_CNT_EN.
module tb_matmul_sequencer;
    localparam int A_ROWS = 64, B_COLS = 64, ADDR_A_W = 6, ADDR_B_W = 6, ADDR_OUT_W = 12;
    localparam int MEM_LAT = 1, TREE_LAT = 7;
    localparam int LAT = MEM_LAT + TREE_LAT;
    localparam int NPAIR = A_ROWS * B_COLS;
    localparam int K = 8;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0;
    logic en_A, we_A, en_B, we_B, en_out, we_out, busy, done;
    logic [ADDR_A_W-1:0]   addr_a;
    logic [ADDR_B_W-1:0]   addr_b;
    logic [ADDR_OUT_W-1:0] addr_out;
`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    matmul_sequencer #(
        .A_ROWS(A_ROWS), .B_COLS(B_COLS), .ADDR_A_W(ADDR_A_W), .ADDR_B_W(ADDR_B_W),
        .ADDR_OUT_W(ADDR_OUT_W), .MEM_LAT(MEM_LAT), .TREE_LAT(TREE_LAT)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef MATMUL_SEQ_PERF_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .start(start), .pause(pause),
        .en_A(en_A), .we_A(we_A), .addr_a(addr_a),
        .en_B(en_B), .we_B(we_B), .addr_b(addr_b),
        .en_out(en_out), .we_out(we_out), .addr_out(addr_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory / adder-tree model and monitor logs
    int A [A_ROWS][K];
    int B [K][B_COLS];
    int pipe [LAT+1];
    int out_mem [NPAIR];
    int iss_c[$], iss_a[$], iss_b[$], wr_c[$], wr_a[$];
    bit pause_log [int];
    int done_rise = -1, busy_cyc = 0, enw_err = 0, wez_err = 0;
    bit done_prev = 1'b0;

    function automatic int dot(input int i, input int j);
        int s = 0;
        for (int k = 0; k < K; k++) s += A[i][k] * B[k][j];
        return s;
    endfunction

    function automatic int qget(input int q[$], input int k);
        return (k >= 0 && k < q.size()) ? q[k] : -1;
    endfunction

    always @(negedge clk) begin
        pause_log[cyc] = pause;
        for (int k = LAT; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = (en_A && en_B) ? dot(int'(addr_a), int'(addr_b)) : -1;
        if (en_A) begin
            iss_c.push_back(cyc);
            iss_a.push_back(int'(addr_a));
            iss_b.push_back(int'(addr_b));
        end
        if (we_out) begin
            wr_c.push_back(cyc);
            wr_a.push_back(int'(addr_out));
            out_mem[addr_out] = pipe[LAT];
        end
        if (en_out !== we_out) enw_err++;
        if (we_A !== 1'b0 || we_B !== 1'b0) wez_err++;
        if (busy) busy_cyc++;
        if (done && !done_prev) done_rise = cyc;
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        for (int i = 0; i < A_ROWS; i++)
            for (int k = 0; k < K; k++) A[i][k] = int'($urandom_range(0, 255));
        for (int k = 0; k < K; k++)
            for (int j = 0; j < B_COLS; j++) B[k][j] = int'($urandom_range(0, 255));
    endtask

    task automatic clear_logs();
        iss_c.delete(); iss_a.delete(); iss_b.delete(); wr_c.delete(); wr_a.delete();
        done_rise = -1;
        busy_cyc = 0;
        for (int n = 0; n < NPAIR; n++) out_mem[n] = -2;
    endtask

    // Reference: from the start cycle on, each cycle with pause low issues the next pair in
    // row-major order one cycle later; its write lands LAT cycles after the issue.
    task automatic check_run(input string tag, input int s);
        int exp_iss[$];
        int c, errs, exp_done;
        c = s;
        while (exp_iss.size() < NPAIR && pause_log.exists(c)) begin
            if (!pause_log[c]) exp_iss.push_back(c + 1);
            c++;
        end
        exp_done = (exp_iss.size() == NPAIR) ? exp_iss[NPAIR-1] + LAT + 1 : -1;

        chk({tag, " issue_count"}, iss_c.size(), NPAIR);
        errs = 0;
        for (int k = 0; k < NPAIR; k++)
            if (qget(iss_c, k) != qget(exp_iss, k) || qget(iss_a, k) != k / B_COLS ||
                qget(iss_b, k) != k % B_COLS) errs++;
        chk({tag, " issue_seq_errs"}, errs, 0);

        chk({tag, " write_count"}, wr_c.size(), NPAIR);
        errs = 0;
        for (int k = 0; k < NPAIR; k++)
            if (qget(wr_c, k) != qget(exp_iss, k) + LAT || qget(wr_a, k) != k) errs++;
        chk({tag, " write_seq_errs"}, errs, 0);

        chk({tag, " done_cycle"}, done_rise, exp_done);
        chk({tag, " busy_cycles"}, busy_cyc, exp_done - (s + 1));

        errs = 0;
        for (int n = 0; n < NPAIR; n++)
            if (out_mem[n] != dot(n / B_COLS, n % B_COLS)) errs++;
        chk({tag, " data_errs"}, errs, 0);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        chk({tag, " cycle_cnt"}, cycle_cnt, exp_done - (s + 1));
`endif
    endtask

    task automatic run(input string tag, input int p_at, input int p_len, input int rnd_from,
                       input int rnd_div, input int st1, input int st2, output int s);
        new_data();
        clear_logs();
        s = cyc;
        start = 1'b1;
        pause = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, " rel1_busy_done"}, {busy, done}, 2'b10);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        chk({tag, " rel1_cycle_cnt"}, cycle_cnt, 0);
`endif
        for (int r = 1; r < 12000 && !done; r++) begin
            pause = (r >= p_at && r < p_at + p_len);
            if (r >= rnd_from) pause = ($urandom_range(0, rnd_div - 1) == 0);
            start = (r == st1 || r == st2);
            tick();
        end
        start = 1'b0;
        pause = 1'b0;
        chk({tag, " done_seen"}, done, 1);
        for (int r = 0; r < 4; r++) tick();
        chk({tag, " done_hold"}, {busy, done}, 2'b01);
        check_run(tag, s);
    endtask

    initial begin
        int s, n_wr, p;

        for (int r = 0; r < 3; r++) tick();
        chk("reset_outputs_in_rst",
            {en_A, we_A, addr_a, en_B, we_B, addr_b, en_out, we_out, addr_out, busy, done}, 0);
        rst = 1'b0;
        tick();
        chk("idle_outputs",
            {en_A, we_A, addr_a, en_B, we_B, addr_b, en_out, we_out, addr_out, busy, done}, 0);

        // Plain run with test-plan timing constants
        run("r1", NEVER, 0, NEVER, 1, -1, -1, s);
        chk("r1 first_issue_rel", qget(iss_c, 0) - s, 1);
        chk("r1 first_issue_addr", qget(iss_a, 0) * 100 + qget(iss_b, 0), 0);
        chk("r1 first_write_rel", qget(wr_c, 0) - s, 9);
        chk("r1 first_write_addr", qget(wr_a, 0), 0);
        chk("r1 last_write_rel", qget(wr_c, NPAIR - 1) - s, 4104);
        chk("r1 last_write_addr", qget(wr_a, NPAIR - 1), 4095);
        chk("r1 done_rel", done_rise - s, 4105);

        // 10-cycle pause at pair (3,17); random pause during drain must not matter
        run("r2", 3 * B_COLS + 17, 10, 4107, 2, -1, -1, s);
        chk("r2 resume_rel", qget(iss_c, 3 * B_COLS + 17) - s, 220);
        chk("r2 issue_gap", qget(iss_c, 3 * B_COLS + 17) - qget(iss_c, 3 * B_COLS + 16), 11);
        chk("r2 write_gap", qget(wr_c, 3 * B_COLS + 17) - qget(wr_c, 3 * B_COLS + 16), 11);
        chk("r2 done_rel", done_rise - s, 4115);

        // Reset in the middle of a run
        new_data();
        clear_logs();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r < 2000; r++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r3 outputs_after_reset",
            {en_A, we_A, addr_a, en_B, we_B, addr_b, en_out, we_out, addr_out, busy, done}, 0);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        chk("r3 cycle_cnt_after_reset", cycle_cnt, 0);
`endif
        n_wr = wr_c.size();
        chk("r3 writes_before_reset", n_wr, 2000 - LAT);
        for (int r = 0; r < 40; r++) tick();
        chk("r3 no_write_after_reset", wr_c.size() - n_wr, 0);
        chk("r3 issues_before_reset", iss_c.size(), 2000);

        // Starts while busy are ignored
        run("r4", NEVER, 0, NEVER, 1, 100, 4104, s);
        chk("r4 done_rel", done_rise - s, 4105);

        // Start from DONE with a 5-cycle pause somewhere in the issue phase
        p = int'($urandom_range(50, 4000));
        run("r5", p, 5, NEVER, 1, -1, -1, s);
        chk("r5 done_rel", done_rise - s, 4110);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        chk("r5 cycle_cnt_4109", cycle_cnt, 4109);
`endif

        // Random pause throughout
        run("r6", NEVER, 0, 1, 4, -1, -1, s);

        chk("en_out_eq_we_out_errs", enw_err, 0);
        chk("we_A_we_B_zero_errs", wez_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
